// File: rtl/yarith_arbiter.sv
// Round-robin scheduler sharing one external add/subtract unit among N requesters.
// Optional `define YARITH_ARB_OVF_EN adds a registered signed-overflow flag (rsp_ovf).
module yarith_arbiter #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N-1:0]   req_ctrl,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_ctrl,
  input  logic [W-1:0]   alu_z,
  input  logic           alu_cout,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_z,
  output logic           rsp_cout
`ifdef YARITH_ARB_OVF_EN
  ,
  output logic           rsp_ovf
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] id_reg;

  logic [W-1:0]   op_a [N];
  logic [W-1:0]   op_b [N];

  logic           window;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] ptr_next;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign op_a[gi] = req_a[gi*W +: W];
    assign op_b[gi] = req_b[gi*W +: W];
  end

  // A new grant may overlap the cycle in which the held response is consumed.
  assign window = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);

  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] sel;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    sel     = '0;
    if (rst_n && window) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_reg) + k;
        if (idx >= N) idx = idx - N;
        sel = IDW'(idx);
        if (!gnt_any && req[sel]) begin
          gnt[sel] = 1'b1;
          gnt_any  = 1'b1;
          gnt_idx  = sel;
        end
      end
    end
  end

  assign ptr_next  = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
  assign rsp_valid = (state_reg == RESP);

`ifdef YARITH_ARB_OVF_EN
  logic ovf_next;
  assign ovf_next = (alu_ctrl ? (alu_a[W-1] != alu_b[W-1]) : (alu_a[W-1] == alu_b[W-1]))
                    && (alu_z[W-1] != alu_a[W-1]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      rsp_cout  <= 1'b0;
`ifdef YARITH_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else if (gnt_any) begin
      alu_a     <= op_a[gnt_idx];
      alu_b     <= op_b[gnt_idx];
      alu_ctrl  <= req_ctrl[gnt_idx];
      id_reg    <= gnt_idx;
      ptr_reg   <= ptr_next;
      state_reg <= EXEC;
    end else if (state_reg == EXEC) begin
      rsp_z     <= alu_z;
      rsp_cout  <= alu_cout;
      rsp_id    <= id_reg;
`ifdef YARITH_ARB_OVF_EN
      rsp_ovf   <= ovf_next;
`endif
      state_reg <= RESP;
    end else if (state_reg == RESP) begin
      if (rsp_ready) state_reg <= IDLE;
    end else begin
      state_reg <= IDLE;
    end
  end

endmodule

// File: tb/tb_yarith_arbiter.sv
// Self-checking bench for yarith_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model; honours YARITH_ARB_OVF_EN when defined.
module tb_yarith_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ctrl;
  logic [N-1:0]   gnt;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic           alu_ctrl;
  logic [W-1:0]   alu_z;
  logic           alu_cout;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_z;
  logic           rsp_cout;
`ifdef YARITH_ARB_OVF_EN
  logic           rsp_ovf;
`endif

  always #5 clk = ~clk;

  // External shared unit: A + (sub ? ~B : B) + sub
  logic [W:0] alu_sum;
  assign alu_sum  = {1'b0, alu_a} + {1'b0, (alu_ctrl ? ~alu_b : alu_b)} + {{W{1'b0}}, alu_ctrl};
  assign alu_z    = alu_sum[W-1:0];
  assign alu_cout = alu_sum[W];

  yarith_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_ctrl(req_ctrl), .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_z(alu_z), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .rsp_cout(rsp_cout)
`ifdef YARITH_ARB_OVF_EN
    , .rsp_ovf(rsp_ovf)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending requests, rotation pointer, in-flight and held operations
  bit         pend [N];
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];
  bit         pc [N];
  int         m_ptr;
  bit         m_exec, m_resp;
  logic [W-1:0] x_a, x_b;
  bit         x_c;
  int         x_id;
  logic [W-1:0] e_z;
  bit         e_cout, e_ovf;
  int         e_id;
  int         last_gnt;
  int         cyc = 0;
  int         refill = 0;
  int         gq[$];
  int         gcyc[$];

  function automatic void ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                                 output logic [W-1:0] z, output bit cout, output bit ovf);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      z    = a - b;
      cout = (a >= b);
      r    = sa - sb;
    end else begin
      z    = a + b;
      cout = (longint'(a) + longint'(b)) > 64'sd4294967295;
      r    = sa + sb;
    end
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom % 5)
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
    pend[i] = 1'b1; pa[i] = a; pb[i] = b; pc[i] = c;
  endtask

  task automatic drive(input bit ready);
    for (int i = 0; i < N; i++) begin
      req[i]            = pend[i];
      req_a[i*W +: W]   = pa[i];
      req_b[i*W +: W]   = pb[i];
      req_ctrl[i]       = pc[i];
    end
    rsp_ready = ready;
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model, step the clock.
  task automatic cycle(input bit ready);
    int w, j;
    bit window;
    logic [N-1:0] eg;
    drive(ready);
    #2;
    chk("rsp_valid", rsp_valid, m_resp);
    if (m_resp) begin
      chk("rsp_id", rsp_id, e_id);
      chk("rsp_z", rsp_z, e_z);
      chk("rsp_cout", rsp_cout, e_cout);
`ifdef YARITH_ARB_OVF_EN
      chk("rsp_ovf", rsp_ovf, e_ovf);
`endif
    end
    if (m_exec) begin
      chk("alu_a", alu_a, x_a);
      chk("alu_b", alu_b, x_b);
      chk("alu_ctrl", alu_ctrl, x_c);
    end
    window = !m_exec && (!m_resp || ready);
    w = -1;
    if (window) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (w < 0 && pend[j]) w = j;
      end
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    chk("gnt", gnt, eg);
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) begin
        gq.push_back(k);
        gcyc.push_back(cyc);
        last_gnt = k;
      end
    end
    if (m_exec) begin
      ref_op(x_a, x_b, x_c, e_z, e_cout, e_ovf);
      e_id   = x_id;
      m_resp = 1'b1;
      m_exec = 1'b0;
    end else if (m_resp && ready) begin
      m_resp = 1'b0;
    end
    if (w >= 0) begin
      m_exec = 1'b1;
      x_a = pa[w]; x_b = pb[w]; x_c = pc[w]; x_id = w;
      pend[w] = 1'b0;
      m_ptr = (w + 1) % N;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (refill == 1 || (refill == 2 && ($urandom % 2) == 1)))
        set_op(i, rnd_word(), rnd_word(), bit'($urandom % 2));
    end
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0;
    drive(1'b1);
    #2;
    chk("gnt_in_reset", gnt, 0);
    @(posedge clk);
    #1;
    cyc++;
    rst_n  = 1'b1;
    m_ptr  = 0;
    m_exec = 1'b0;
    m_resp = 1'b0;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_z", rsp_z, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
`ifdef YARITH_ARB_OVF_EN
    chk("rst_ovf", rsp_ovf, 0);
`endif
  endtask

  task automatic clear_pend();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; pa[i] = '0; pb[i] = '0; pc[i] = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; req_a = '0; req_b = '0; req_ctrl = '0; rsp_ready = 1'b0;
    clear_pend();
    last_gnt = -1;
    @(posedge clk);
    #1;
    reset_cycle();

    // Add from requester 0
    set_op(0, 32'd5, 32'd3, 1'b0);
    cycle(1'b1);
    chk("add_gnt_idx", last_gnt, 0);
    cycle(1'b1);
    chk("add_z", rsp_z, 32'd8);
    chk("add_cout", rsp_cout, 0);
    chk("add_id", rsp_id, 0);
    cycle(1'b1);

    // Subtract from requester 2, without and with borrow
    set_op(2, 32'd5, 32'd3, 1'b1);
    cycle(1'b1); cycle(1'b1);
    chk("sub_z", rsp_z, 32'd2);
    chk("sub_cout", rsp_cout, 1);
    cycle(1'b1);
    set_op(2, 32'd3, 32'd5, 1'b1);
    cycle(1'b1); cycle(1'b1);
    chk("sub_borrow_z", rsp_z, 32'hFFFF_FFFE);
    chk("sub_borrow_cout", rsp_cout, 0);
    chk("sub_borrow_id", rsp_id, 2);
    cycle(1'b1);

    // Round robin with all four requesting continuously
    clear_pend();
    reset_cycle();
    refill = 1;
    for (int i = 0; i < N; i++) set_op(i, rnd_word(), rnd_word(), bit'($urandom % 2));
    gq.delete();
    gcyc.delete();
    for (int k = 0; k < 10; k++) cycle(1'b1);
    refill = 0;
    chk("rr_count", (gq.size() >= 5), 1);
    if (gq.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", gq[k], k % N);
        if (k > 0) chk("rr_spacing", gcyc[k] - gcyc[k-1], 2);
      end
    end
    for (int k = 0; k < 10; k++) cycle(1'b1);

    // Backpressure: response held while requester 1 waits
    clear_pend();
    reset_cycle();
    set_op(0, 32'h1234_5678, 32'h0000_1111, 1'b0);
    cycle(1'b1); cycle(1'b1);
    set_op(1, 32'd100, 32'd1, 1'b1);
    for (int k = 0; k < 5; k++) cycle(1'b0);
    chk("bp_held_z", rsp_z, 32'h1234_6789);
    cycle(1'b1);
    chk("bp_gnt1", last_gnt, 1);
    cycle(1'b1); cycle(1'b1);

    // Reset while EXEC: operation discarded, requester 0 regains priority
    set_op(2, 32'd7, 32'd9, 1'b0);
    cycle(1'b1);
    chk("pre_rst_gnt", last_gnt, 2);
    set_op(0, 32'd11, 32'd22, 1'b0);
    set_op(3, 32'd33, 32'd44, 1'b1);
    reset_cycle();
    last_gnt = -1;
    cycle(1'b1);
    chk("rst_prio", last_gnt, 0);
    for (int k = 0; k < 6; k++) cycle(1'b1);

    // Randomized traffic with random backpressure
    refill = 2;
    for (int k = 0; k < 400; k++) cycle(($urandom % 4) != 0);
    refill = 0;
    for (int k = 0; k < 20; k++) cycle(1'b1);

`ifdef YARITH_ARB_OVF_EN
    clear_pend();
    set_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    cycle(1'b1); cycle(1'b1);
    chk("ovf_add", rsp_ovf, 1);
    chk("ovf_add_z", rsp_z, 32'h8000_0000);
    cycle(1'b1);
    set_op(1, 32'h8000_0000, 32'd1, 1'b1);
    cycle(1'b1); cycle(1'b1);
    chk("ovf_sub", rsp_ovf, 1);
    cycle(1'b1);
    set_op(2, 32'd5, 32'd3, 1'b1);
    cycle(1'b1); cycle(1'b1);
    chk("ovf_none", rsp_ovf, 0);
    cycle(1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/yarith_arbiter.md
# yarith_arbiter

Round-robin scheduler that shares one 32-bit add/subtract unit among N requesters. It accepts operand pairs and an add/subtract control bit from each requester and grants one requester at a time. It drives the granted operands into the external arithmetic unit, then captures the sum or difference and carry into a response register held under valid/ready backpressure. It sits between the register-file read ports of several issue slots and the single shared ALU adder.

## Interface
- `N`, default 4: number of requesters. Legal range is 2..8.
- `W`, default 32: operand and result width.
- `IDW`, default 2: width of `rsp_id`. Must equal ceil(log2 N).

- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `req`  in  N  per-requester request, level.
- `req_a`  in  N*W  operand A. Requester i uses bits [i*W +: W].
- `req_b`  in  N*W  operand B, same packing as `req_a`.
- `req_ctrl`  in  N  per-requester control: 0 = add, 1 = subtract.
- `gnt`  out  N  one-hot grant, combinational.
- `alu_a`  out  W  operand A to the shared unit, registered.
- `alu_b`  out  W  operand B to the shared unit, registered.
- `alu_ctrl`  out  1  add/subtract select to the shared unit, registered.
- `alu_z`  in  W  result from the shared unit, combinational in the EXEC cycle.
- `alu_cout`  in  1  carry-out from the shared unit.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_z`  out  W  captured result.
- `rsp_cout`  out  1  captured carry-out.

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - EXEC: operands latched, shared unit evaluating.
  - RESP: response held.
- Grant window: state is IDLE, or state is RESP with `rsp_ready`=1.
  - In the window, `gnt[i]`=1 for the first i with `req[i]`=1, searching upward from `ptr` and wrapping modulo N.
  - Outside the window, or while `rst_n`=0, `gnt`=0.
- Transfer happens when `req[i]` and `gnt[i]` are both 1 at a rising edge. On that edge:
  - `alu_a`/`alu_b`/`alu_ctrl` load requester i's operands.
  - An internal id register loads i.
  - `ptr` loads (i+1) mod N.
  - State goes to EXEC.
- EXEC always lasts exactly one cycle. At its closing edge:
  - `rsp_z` loads `alu_z`, `rsp_cout` loads `alu_cout`, `rsp_id` loads the id register.
  - State goes to RESP.
- RESP: `rsp_valid`=1. All `rsp_*` outputs stay stable until `rsp_ready`=1 at an edge. The next state is then:
  - EXEC if a grant occurred in the same cycle;
  - IDLE otherwise.
- `rsp_valid` is 1 exactly while the state is RESP.
- Carry semantics follow the shared unit. Subtract computes A + ~B + 1, so `cout`=1 means no borrow.
- A requester must hold `req`, operands and ctrl stable from assertion until the cycle `gnt` is seen high. It drops or changes them after that edge.
- A deasserted `req` is never granted. Requests withdrawn before grant are legal.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state = IDLE, `ptr` = 0;
  - `alu_a` = `alu_b` = 0, `alu_ctrl` = 0;
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_z` = 0, `rsp_cout` = 0.
- Reset mid-operation (EXEC or RESP) discards the operation. No response is issued for it, and requester 0 regains top priority.
- Latency, with the grant in cycle T:
  - `alu_*` are valid in T+1;
  - `rsp_valid`=1 from T+2.
- Throughput with `rsp_ready` held at 1: one operation every 2 cycles. The grant coincides with the response handshake cycle.
- Simultaneous requests: exactly one grant per window. The losers keep `req` high and are served in rotating order, so with all N requesting continuously each one is granted once every N grants.
- Pointer wrap: after granting N-1, the search starts at 0.
- `rsp_ready`=1 while the state is not RESP is ignored.

## Configuration
- `YARITH_ARB_OVF_EN` defined: adds output `rsp_ovf` (out, 1), registered alongside `rsp_z`, reset value 0.
  - Add: `rsp_ovf` = (a[W-1]==b[W-1]) && (z[W-1]!=a[W-1]).
  - Subtract: `rsp_ovf` = (a[W-1]!=b[W-1]) && (z[W-1]!=a[W-1]).
  - `a`/`b` are taken from `alu_a`/`alu_b` and `z` from `alu_z` in the EXEC cycle.
- `YARITH_ARB_OVF_EN` undefined: the `rsp_ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
- Add from requester 0: after reset, `req[0]`=1, a=5, b=3, ctrl=0 → `gnt[0]`=1 in cycle T; `rsp_valid` in T+2 with `rsp_z`=8, `rsp_cout`=0, `rsp_id`=0.
- Subtract from requester 2: a=5, b=3, ctrl=1 → `rsp_z`=2, `rsp_cout`=1. Then a=3, b=5, ctrl=1 → `rsp_z`=0xFFFFFFFE, `rsp_cout`=0, `rsp_id`=2.
- Round robin: all four `req` held high with `rsp_ready`=1 → grant order 0,1,2,3,0, one grant every 2 cycles, each `rsp_id` matching its grant.
- Backpressure: `rsp_ready`=0 for 5 cycles while `req[1]` pending → `rsp_*` stable and `gnt`=0 throughout; raising `rsp_ready` gives `gnt[1]` in that same cycle.
- Reset mid-operation: `rst_n`=0 for one edge while in EXEC → next cycle `rsp_valid`=0 and all outputs at reset values; no response for the aborted op; the next simultaneous req[0]/req[3] grants 0.
- With `YARITH_ARB_OVF_EN`: 0x7FFFFFFF + 1 → `rsp_ovf`=1, `rsp_z`=0x80000000. 0x80000000 − 1 → `rsp_ovf`=1. 5 − 3 → `rsp_ovf`=0.
